shift_rr_arbiter: RTL and testbench

//  Shares one 8-bit shift unit between N requesters using round-robin arbitration.

---
 rtl/shift_pkg.sv | 14 +
 rtl/shift_core.sv | 47 ++++
 rtl/shift_rr_arbiter.sv | 110 +++++++++++
 tb/tb_shift_rr_arbiter.sv | 188 ++++++++++++++++++
 4 files changed

// File: rtl/shift_pkg.sv
// Shared constants for the round-robin shift unit.
// Op codes and FSM state encodings.
package shift_pkg;

  localparam logic [1:0] OP_SLL = 2'b00;
  localparam logic [1:0] OP_SRL = 2'b01;
  localparam logic [1:0] OP_SRA = 2'b10;
  localparam logic [1:0] OP_ROL = 2'b11;

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_EXEC = 2'd1;
  localparam logic [1:0] S_RESP = 2'd2;

endpackage

// File: rtl/shift_core.sv
// Combinational log-stage barrel shifter.
// Shift amounts of WIDTH or more are clamped; rotates wrap.
module shift_core
  import shift_pkg::*;
#(
  parameter int WIDTH = 8
) (
  input  logic [WIDTH-1:0] a,
  input  logic [7:0]       b,
  input  logic [1:0]       op,
  output logic [WIDTH-1:0] y
);

  localparam int SW = (WIDTH > 1) ? $clog2(WIDTH) : 1;

  logic [SW-1:0]    amt;
  logic             over;
  logic [WIDTH-1:0] v;

  always_comb begin
    over = (b >= 8'(WIDTH));
    amt  = (op == OP_ROL) ? SW'(b % 8'(WIDTH)) : SW'(b);
    v    = a;
    for (int k = 0; k < SW; k++) begin
      if (amt[k]) begin
        unique case (op)
          OP_SLL: v = v << (1 << k);
          OP_SRL: v = v >> (1 << k);
          OP_SRA: v = WIDTH'($signed(v) >>> (1 << k));
          OP_ROL: v = (v << (1 << k)) | (v >> (WIDTH - (1 << k)));
          default: v = v;
        endcase
      end
    end
    y = v;
    // Rotate never overflows; the linear shifts saturate to their fill.
    if (over) begin
      unique case (op)
        OP_SLL: y = '0;
        OP_SRL: y = '0;
        OP_SRA: y = {WIDTH{a[WIDTH-1]}};
        default: y = v;
      endcase
    end
  end

endmodule

// File: rtl/shift_rr_arbiter.sv
// Round-robin arbiter sharing one shift_core among N requesters.
// Sequence per op: grant/capture, execute, hold registered response.
module shift_rr_arbiter
  import shift_pkg::*;
#(
  parameter int WIDTH = 8,
  parameter int N     = 4,
  localparam int IDW  = $clog2(N)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [N-1:0]     req_valid,
  output logic [N-1:0]     req_ready,
  input  logic [N*WIDTH-1:0] req_a,
  input  logic [N*8-1:0]   req_b,
  input  logic [N*2-1:0]   req_op,
  output logic             rsp_valid,
  input  logic             rsp_ready,
  output logic [WIDTH-1:0] rsp_data,
  output logic [IDW-1:0]   rsp_id
);

  logic [1:0]       state;
  logic [IDW-1:0]   ptr;
  logic [IDW-1:0]   grant;
  logic [IDW:0]     scan;
  logic             any;
  logic             fire;
  logic [WIDTH-1:0] cap_a;
  logic [7:0]       cap_b;
  logic [1:0]       cap_op;
  logic [IDW-1:0]   cap_id;
  logic [IDW-1:0]   next_ptr;
  logic [WIDTH-1:0] y;

  // Scan from the farthest slot back to ptr so the nearest valid wins.
  always_comb begin
    grant = '0;
    scan  = '0;
    for (int j = N - 1; j >= 0; j--) begin
      scan = {1'b0, ptr} + (IDW + 1)'(j);
      if (scan >= (IDW + 1)'(N)) begin
        scan = scan - (IDW + 1)'(N);
      end
      if (req_valid[scan[IDW-1:0]]) begin
        grant = scan[IDW-1:0];
      end
    end
  end

  always_comb begin
    any       = |req_valid;
    fire      = (state == S_IDLE) && any;
    req_ready = '0;
    if (fire) begin
      req_ready[grant] = 1'b1;
    end
    next_ptr = (cap_id == IDW'(N - 1)) ? '0 : cap_id + 1'b1;
  end

  shift_core #(
    .WIDTH(WIDTH)
  ) u_core (
    .a (cap_a),
    .b (cap_b),
    .op(cap_op),
    .y (y)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= S_IDLE;
      ptr       <= '0;
      cap_a     <= '0;
      cap_b     <= '0;
      cap_op    <= '0;
      cap_id    <= '0;
      rsp_valid <= 1'b0;
      rsp_data  <= '0;
      rsp_id    <= '0;
    end else begin
      unique case (state)
        S_IDLE: begin
          if (fire) begin
            cap_a  <= req_a[grant*WIDTH +: WIDTH];
            cap_b  <= req_b[grant*8 +: 8];
            cap_op <= req_op[grant*2 +: 2];
            cap_id <= grant;
            state  <= S_EXEC;
          end
        end
        S_EXEC: begin
          rsp_data  <= y;
          rsp_id    <= cap_id;
          rsp_valid <= 1'b1;
          state     <= S_RESP;
        end
        S_RESP: begin
          if (rsp_ready) begin
            rsp_valid <= 1'b0;
            ptr       <= next_ptr;
            state     <= S_IDLE;
          end
        end
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_shift_rr_arbiter.sv
// Directed bench for shift_rr_arbiter with hand-computed results.
// WIDTH=8, N=4.
module tb_shift_rr_arbiter;

  logic        clk = 1'b0;
  logic        rst;
  logic [3:0]  req_valid;
  logic [3:0]  req_ready;
  logic [31:0] req_a;
  logic [31:0] req_b;
  logic [7:0]  req_op;
  logic        rsp_valid;
  logic        rsp_ready;
  logic [7:0]  rsp_data;
  logic [1:0]  rsp_id;

  int vectors = 0;
  int miscompares = 0;

  always #5 clk = ~clk;

  shift_rr_arbiter #(.WIDTH(8), .N(4)) dut (
    .clk      (clk),
    .rst      (rst),
    .req_valid(req_valid),
    .req_ready(req_ready),
    .req_a    (req_a),
    .req_b    (req_b),
    .req_op   (req_op),
    .rsp_valid(rsp_valid),
    .rsp_ready(rsp_ready),
    .rsp_data (rsp_data),
    .rsp_id   (rsp_id)
  );

  task automatic chk(input string tag, input logic [31:0] obs,
                     input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic set_req(input int i, input logic [7:0] a,
                         input logic [7:0] b, input logic [1:0] op);
    req_a[i*8 +: 8] = a;
    req_b[i*8 +: 8] = b;
    req_op[i*2 +: 2] = op;
    req_valid[i] = 1'b1;
  endtask

  // Entered just after an edge with the DUT idle and rsp_ready=1.
  task automatic run1(input string tag, input int i, input logic [7:0] a,
                      input logic [7:0] b, input logic [1:0] op,
                      input logic [7:0] expd);
    set_req(i, a, b, op);
    @(negedge clk);
    chk({tag, "_ready"}, 32'(req_ready), 32'(4'b0001 << i));
    tick();
    req_valid[i] = 1'b0;
    @(negedge clk);
    chk({tag, "_exec_valid"}, 32'(rsp_valid), 32'd0);
    tick();
    @(negedge clk);
    chk({tag, "_valid"}, 32'(rsp_valid), 32'd1);
    chk({tag, "_data"}, 32'(rsp_data), 32'(expd));
    chk({tag, "_id"}, 32'(rsp_id), 32'(i));
    tick();
  endtask

  initial begin
    rst = 1'b1;
    req_valid = '0;
    req_a = '0;
    req_b = '0;
    req_op = '0;
    rsp_ready = 1'b0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk("rst_valid", 32'(rsp_valid), 32'd0);
    chk("rst_data", 32'(rsp_data), 32'd0);
    chk("rst_id", 32'(rsp_id), 32'd0);
    chk("rst_ready", 32'(req_ready), 32'd0);
    tick();
    rst = 1'b0;
    rsp_ready = 1'b1;

    // Basic op and latency
    run1("sll2", 0, 8'h96, 8'd2, 2'b00, 8'h58);
    @(negedge clk);
    chk("sll2_drop", 32'(rsp_valid), 32'd0);
    tick();

    // Range and sign cases
    run1("sra9", 0, 8'h96, 8'd9, 2'b10, 8'hFF);
    run1("srl8", 0, 8'h96, 8'd8, 2'b01, 8'h00);
    run1("rol11", 0, 8'h96, 8'd11, 2'b11, 8'hB4);
    run1("sra3", 0, 8'h96, 8'd3, 2'b10, 8'hF2);
    run1("srl1", 0, 8'h96, 8'd1, 2'b01, 8'h4B);
    run1("sll8", 0, 8'h96, 8'd8, 2'b00, 8'h00);
    run1("rol0", 0, 8'h96, 8'd0, 2'b11, 8'h96);
    run1("sll255", 0, 8'h01, 8'd255, 2'b00, 8'h00);

    // Backpressure: ptr=1, req1 and req3 valid
    rsp_ready = 1'b0;
    set_req(1, 8'h81, 8'd1, 2'b10);
    set_req(3, 8'h3C, 8'd2, 2'b01);
    @(negedge clk);
    chk("bp_grant1", 32'(req_ready), 32'b0010);
    tick();
    req_valid[1] = 1'b0;
    tick();
    for (int c = 0; c < 5; c++) begin
      @(negedge clk);
      chk("bp_valid", 32'(rsp_valid), 32'd1);
      chk("bp_data", 32'(rsp_data), 32'hC0);
      chk("bp_id", 32'(rsp_id), 32'd1);
      chk("bp_ready0", 32'(req_ready), 32'd0);
      tick();
    end
    rsp_ready = 1'b1;
    tick();
    @(negedge clk);
    chk("bp_release", 32'(rsp_valid), 32'd0);
    chk("bp_grant3", 32'(req_ready), 32'b1000);
    req_valid[3] = 1'b0;
    tick();
    run1("srl3c", 3, 8'h3C, 8'd2, 2'b01, 8'h0F);

    // Reset during EXEC
    set_req(2, 8'h0F, 8'd4, 2'b00);
    @(negedge clk);
    chk("rst_grant2", 32'(req_ready), 32'b0100);
    tick();
    req_valid = '0;
    rst = 1'b1;
    #1;
    chk("mid_rst_valid", 32'(rsp_valid), 32'd0);
    chk("mid_rst_ready", 32'(req_ready), 32'd0);
    tick();
    rst = 1'b0;
    for (int c = 0; c < 4; c++) begin
      @(negedge clk);
      chk("no_stale", 32'(rsp_valid), 32'd0);
      tick();
    end

    // All four requesters valid, ptr back at 0
    for (int i = 0; i < 4; i++) begin
      set_req(i, 8'h96, 8'(i), 2'b00);
    end
    for (int k = 0; k < 5; k++) begin
      logic [7:0] ex [4];
      ex[0] = 8'h96;
      ex[1] = 8'h2C;
      ex[2] = 8'h58;
      ex[3] = 8'hB0;
      @(negedge clk);
      chk("rr_grant", 32'(req_ready), 32'(4'b0001 << (k % 4)));
      tick();
      @(negedge clk);
      chk("rr_exec", 32'(req_ready | {3'b0, rsp_valid}), 32'd0);
      tick();
      @(negedge clk);
      chk("rr_valid", 32'(rsp_valid), 32'd1);
      chk("rr_id", 32'(rsp_id), 32'(k % 4));
      chk("rr_data", 32'(rsp_data), 32'(ex[k % 4]));
      tick();
    end
    req_valid = '0;

    // ptr=1: serve req3, then req2 alone wraps through 0
    run1("wrap3", 3, 8'h80, 8'd7, 2'b10, 8'hFF);
    run1("wrap2", 2, 8'h0F, 8'd4, 2'b11, 8'hF0);
    run1("next0", 0, 8'h01, 8'd7, 2'b00, 8'h80);

    $display("== %0d vectors applied, %0d miscompares ==", vectors,
             miscompares);
    $finish;
  end

endmodule
